// File: rtl/qsys_pulse_out_pio.sv
// Avalon-MM output PIO: DATA/SET/CLEAR lines plus a shared one-shot invert timer with sticky done/IRQ.
// Latency: writes reach out_port one clock after the accepting edge; readdata is registered (read latency 1).
// Backpressure: none; every chipselect write is accepted without wait states.
module qsys_pulse_out_pio #(
    parameter int                 WIDTH       = 8,
    parameter int                 PW_BITS     = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq,
    output logic [WIDTH-1:0]   out_port
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [PW_BITS-1:0] PW_ONE = PW_BITS'(1);

    state_t               state, state_next;
    logic [WIDTH-1:0]     data_reg, data_next;
    logic [WIDTH-1:0]     mask_reg, mask_next;
    logic [WIDTH-1:0]     out_next;
    logic [PW_BITS-1:0]   pw_reg, pw_next;
    logic [PW_BITS-1:0]   cnt_reg, cnt_next;
    logic                 done_reg, done_next, done_set;
    logic                 irq_mask_reg, irq_mask_next;
    logic [31:0]          rd_next;
    logic                 wr, busy;
    logic [WIDTH-1:0]     wd_w;
    logic [PW_BITS-1:0]   wd_pw;
    logic                 unused_wd;

    assign wr        = chipselect & ~write_n;
    assign busy      = (state == ACTIVE);
    assign wd_w      = writedata[WIDTH-1:0];
    assign wd_pw     = writedata[PW_BITS-1:0];
    assign unused_wd = ^writedata;
    assign irq       = done_reg & irq_mask_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            data_reg     <= RESET_VALUE;
            mask_reg     <= '0;
            pw_reg       <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            irq_mask_reg <= 1'b0;
            readdata     <= '0;
            out_port     <= RESET_VALUE;
        end else begin
            state        <= state_next;
            data_reg     <= data_next;
            mask_reg     <= mask_next;
            pw_reg       <= pw_next;
            cnt_reg      <= cnt_next;
            done_reg     <= done_next;
            irq_mask_reg <= irq_mask_next;
            readdata     <= rd_next;
            out_port     <= out_next;
        end
    end

    always_comb begin
        state_next    = state;
        data_next     = data_reg;
        mask_next     = mask_reg;
        pw_next       = pw_reg;
        cnt_next      = cnt_reg;
        done_next     = done_reg;
        irq_mask_next = irq_mask_reg;
        done_set      = 1'b0;

        if (wr) begin
            case (address)
                3'd0:    data_next     = wd_w;
                3'd1:    data_next     = data_reg | wd_w;
                3'd2:    data_next     = data_reg & ~wd_w;
                3'd3:    pw_next       = wd_pw;
                3'd6:    irq_mask_next = writedata[0];
                default: ;
            endcase
        end

        // A PULSE write while ACTIVE falls through untouched: no restart, no mask change.
        unique case (state)
            IDLE: begin
                if (wr && address == 3'd4 && pw_reg != '0) begin
                    state_next = ACTIVE;
                    cnt_next   = pw_reg;
                    mask_next  = wd_w;
                end
            end
            ACTIVE: begin
                cnt_next = cnt_reg - PW_ONE;
                if (cnt_reg == PW_ONE) begin
                    state_next = IDLE;
                    mask_next  = '0;
                    done_set   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Completion beats a same-edge write-1-to-clear.
        if (done_set)
            done_next = 1'b1;
        else if (wr && address == 3'd5 && writedata[1])
            done_next = 1'b0;

        out_next = data_next ^ ((state_next == ACTIVE) ? mask_next : '0);

        case (address)
            3'd0, 3'd1, 3'd2: rd_next = 32'(data_reg);
            3'd3:             rd_next = 32'(pw_reg);
            3'd4:             rd_next = 32'(mask_reg);
            3'd5:             rd_next = {30'd0, done_reg, busy};
            3'd6:             rd_next = {31'd0, irq_mask_reg};
            default:          rd_next = '0;
        endcase
    end

endmodule

// File: tb/tb_qsys_pulse_out_pio.sv
// Scoreboarded random + directed bench for qsys_pulse_out_pio against an end-time based pulse model.
module tb_qsys_pulse_out_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  out_port;

    qsys_pulse_out_pio #(.WIDTH(8), .PW_BITS(16), .RESET_VALUE(8'h00)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  out;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a pulse is remembered only by the edge number at which it ends.
    int          n_edge;
    int          m_end;
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [15:0] m_pw;
    logic        m_done;
    logic        m_irqm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edge = 0;
        m_end  = -1;
        m_data = 8'h00;
        m_mask = 8'h00;
        m_pw   = 16'h0;
        m_done = 1'b0;
        m_irqm = 1'b0;
    endtask

    task automatic model_edge();
        exp_t e;
        bit   busy_pre, busy_post, dset, wr, clr;
        int   n;
        n_edge++;
        n = n_edge;
        busy_pre = (n - 1) < m_end;
        case (address)
            3'd0, 3'd1, 3'd2: e.rd = {24'd0, m_data};
            3'd3:             e.rd = {16'd0, m_pw};
            3'd4:             e.rd = busy_pre ? {24'd0, m_mask} : 32'd0;
            3'd5:             e.rd = {30'd0, m_done, busy_pre};
            3'd6:             e.rd = {31'd0, m_irqm};
            default:          e.rd = 32'd0;
        endcase
        wr   = chipselect && !write_n;
        dset = (n == m_end);
        clr  = 1'b0;
        if (wr) begin
            case (address)
                3'd0: m_data = writedata[7:0];
                3'd1: m_data = m_data | writedata[7:0];
                3'd2: m_data = m_data & ~writedata[7:0];
                3'd3: m_pw   = writedata[15:0];
                3'd4: if (!busy_pre && m_pw != 0) begin
                          m_mask = writedata[7:0];
                          m_end  = n + int'(m_pw);
                      end
                3'd5: clr    = writedata[1];
                3'd6: m_irqm = writedata[0];
                default: ;
            endcase
        end
        m_done    = dset ? 1'b1 : (clr ? 1'b0 : m_done);
        busy_post = n < m_end;
        e.out     = m_data ^ (busy_post ? m_mask : 8'h00);
        e.irq     = m_done & m_irqm;
        q.push_back(e);
    endtask

    // Called at a negedge: drive, predict, then advance one clock.
    task automatic cyc(input bit cs, input bit w, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = !w;
        address    = a;
        writedata  = d;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("out_port", {24'd0, out_port}, {24'd0, e.out});
            check("readdata", readdata, e.rd);
            check("irq", {31'd0, irq}, {31'd0, e.irq});
        end
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_readdata", readdata, 32'd0);
        check("reset_out_port", {24'd0, out_port}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;

        rd(3'd0);
        wr(3'd0, 32'hFFFF_FFA5);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h81);
        rd(3'd1);
        idle(1);

        wr(3'd3, 32'd3);
        wr(3'd0, 32'h00);
        wr(3'd6, 32'h1);
        wr(3'd4, 32'h01);
        rd(3'd5);
        rd(3'd4);
        rd(3'd5);
        rd(3'd5);
        wr(3'd5, 32'h2);
        rd(3'd5);

        wr(3'd3, 32'd10);
        wr(3'd4, 32'h03);
        idle(2);
        wr(3'd4, 32'hF0);
        rd(3'd4);
        wr(3'd3, 32'd7);
        wr(3'd1, 32'h01);
        idle(6);
        rd(3'd5);

        wr(3'd3, 32'd0);
        wr(3'd5, 32'h2);
        wr(3'd4, 32'hFF);
        rd(3'd5);
        idle(1);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'h00);
        idle(2);
        rd(3'd5);

        wr(3'd3, 32'd100);
        wr(3'd0, 32'h00);
        wr(3'd4, 32'h0F);
        idle(5);
        reset_n = 1'b0;
        #1;
        check("async_reset_out_port", {24'd0, out_port}, 32'd0);
        check("async_reset_irq", {31'd0, irq}, 32'd0);
        check("async_reset_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        rd(3'd5);
        wr(3'd3, 32'd5);
        wr(3'd4, 32'h3C);
        idle(6);
        rd(3'd5);

        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3) d = $urandom_range(0, 12);
            if ($urandom_range(0, 2) != 0)
                cyc(1'b1, $urandom_range(0, 1) == 1, a, d);
            else
                cyc(1'b0, $urandom_range(0, 1) == 1, a, d);
        end

        idle(2);
        check("scoreboard_drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qsys_pulse_out_pio.md
Name: qsys_pulse_out_pio

Overview:
- Avalon-MM slave output port; the outbound counterpart of the edge-capture interrupt input PIO.
- The CPU drives WIDTH output lines through direct-write, set and clear registers.
- A shared one-shot timer inverts selected lines for a programmed number of clocks, then restores them.
- Pulse completion sets a sticky done flag that can raise a maskable IRQ.
- Sits between the HPS/Nios bus fabric and board-level control strobes, e.g. sensor trigger or driver enable.

Parameters:
WIDTH, 8, number of output lines (1..32)
PW_BITS, 16, width of pulse-length register and down-counter (1..32)
RESET_VALUE, 0, out_port/DATA value after reset (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  level interrupt, done & irq_mask
out_port  out  WIDTH  registered output lines

Behaviour:
- One clock domain; reset is asynchronous and active-low on reset_n; all flops use clk.
- Write accepted on any edge with chipselect=1 and write_n=0. No wait states.
- Reset values: DATA=RESET_VALUE, out_port=RESET_VALUE, PULSE_WIDTH=0, mask=0, counter=0, busy=0, done=0, irq_mask=0, readdata=0, irq=0.
- Register map (writedata bits above the field width are ignored; unused read bits are 0):
  - 0 DATA (R/W): DATA <= writedata[WIDTH-1:0].
  - 1 SET (W): DATA <= DATA | wd. Reads return DATA.
  - 2 CLEAR (W): DATA <= DATA & ~wd. Reads return DATA.
  - 3 PULSE_WIDTH (R/W): PW_BITS-bit cycle count.
  - 4 PULSE (W): start one-shot with mask = wd[WIDTH-1:0]. Reads return the active mask (0 when idle).
  - 5 STATUS: bit0 = busy (RO), bit1 = done. Writing 1 to bit1 clears done.
  - 6 IRQ_MASK (R/W): bit0.
  - 7: reads 0, writes ignored.
- Read path:
  - readdata is registered every clock from the address mux, independent of chipselect.
  - Data is valid on the cycle after the address is presented (read latency 1).
- out_port register:
  - Each edge, out_port <= DATA_next ^ (busy_next ? mask_next : 0).
  - Any write effect on out_port appears the cycle after the accepting edge.
- Timer FSM:
  - IDLE to ACTIVE: on a PULSE write with PULSE_WIDTH != 0. Load counter = PULSE_WIDTH, latch mask, set busy.
  - ACTIVE: counter decrements every clock. When counter == 1, the next edge returns to IDLE, clears busy, zeroes mask and sets done.
  - Net effect: lines are inverted for exactly PULSE_WIDTH cycles.
- Boundary rules:
  - PULSE write while busy is ignored entirely (no restart, no mask change).
  - PULSE write with PULSE_WIDTH = 0 is ignored; done is not set.
  - PULSE with mask = 0 still runs the timer and sets done, so it can serve as a pure delay timer.
  - PULSE_WIDTH writes during ACTIVE affect only the next pulse.
  - DATA/SET/CLEAR writes during ACTIVE update DATA immediately; out_port shows new DATA ^ mask.
  - Same-edge done clear and done set: set wins.
  - Counter width is PW_BITS, so the maximum pulse is 2^PW_BITS - 1 cycles; there is no wrap.
- Reset mid-pulse aborts immediately: out_port returns to RESET_VALUE asynchronously and done stays 0.

Test Plan:
- Reset then read addr 0 -> readdata=0x00 one cycle later; out_port=0x00; irq=0.
- Write DATA=0xA5, SET=0x0F, CLEAR=0x81 -> out_port steps 0xA5, then 0xAF, then 0x2E, each one cycle after its write; read addr 1 returns 0x2E.
- PULSE_WIDTH=3, DATA=0x00, PULSE=0x01:
  - out_port=0x01 for exactly 3 cycles, then 0x00.
  - busy reads 1 during the pulse; done=1 afterward.
  - With IRQ_MASK=1, irq rises with done; writing STATUS=0x2 drops irq next cycle.
- During an active PULSE_WIDTH=10 pulse with mask 0x03:
  - A second PULSE=0xF0 is ignored; out_port keeps 0x03 for the remaining cycles.
  - SET=0x01 mid-pulse -> out_port shows 0x02 until the pulse ends, then 0x01.
- PULSE_WIDTH=0 then PULSE=0xFF -> out_port unchanged, busy stays 0, done stays 0. PULSE_WIDTH=2 with PULSE=0x00 -> done=1 after 2 cycles, out_port unchanged.
- Assert reset_n low mid-pulse (PULSE_WIDTH=100) -> out_port=RESET_VALUE without a clock, busy=0, done=0; after release, a normal 5-cycle pulse completes correctly.
